mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one multi-cycle 32-bit multiplier between N_REQ scheduled datapath states or requesters, such as several dotprod-style calc states or parallel kernels.
- Arbitrates round-robin, latches operands and sequences the multiplier latency.
- Returns the low DW bits of the product with the requester id on one shared response channel.
- Replaces the fixed idle-wait cycles the schedulers currently burn around each multiply.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DW, 32, operand and result width.
- MUL_LAT, 5, multiplier latency in cycles (>=1); the result is valid MUL_LAT cycles after operand capture.
- IDW, $clog2(N_REQ), width of requester id.

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester operation request.
- req_a  in  N_REQ*DW  packed operand A; slice i belongs to requester i.
- req_b  in  N_REQ*DW  packed operand B.
- req_ready  out  N_REQ  one-hot grant/accept; at most one bit high.
- rsp_valid  out  1  result available.
- rsp_id  out  IDW  requester that owns rsp_data.
- rsp_data  out  DW  (a*b) mod 2^DW.
- rsp_ready  in  1  consumer accepts the result.
- busy  out  1  high in CALC or RESP.

Behaviour:
- Reset: the FSM goes to IDLE and rr_ptr to 0. Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0. The cycle counter and operand registers clear to 0.
- FSM states: IDLE, CALC, RESP.
- IDLE, arbitration:
  - The arbiter searches req_valid from rr_ptr upward, wrapping, and picks the first set bit g.
  - req_ready[g] is combinational and asserts in the same cycle as req_valid[g]. It is high only in IDLE.
  - On a handshake (req_valid[g] & req_ready[g]), the block latches req_a[g], req_b[g] and g, sets rr_ptr=(g+1) mod N_REQ, clears cnt and goes to CALC.
  - If no request is pending, the FSM stays in IDLE and rr_ptr is unchanged.
- CALC: cnt increments each cycle. When cnt==MUL_LAT-1, rsp_data is loaded with the product and rsp_id with g, rsp_valid is set and the FSM goes to RESP.
- Latency: a handshake in cycle t gives rsp_valid first high in cycle t+MUL_LAT+1.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - In the rsp_ready cycle the FSM returns to IDLE and rsp_valid drops the next cycle.
  - There is no bypass from RESP to a new grant in the same cycle.
  - The minimum issue interval is MUL_LAT+2 cycles.
- Requester protocol:
  - A requester keeps req_valid and its operands stable until accepted.
  - Deasserting req_valid before the grant is legal and the request is simply dropped.
  - Operand changes after the accept do not affect the result in flight.
- Arithmetic: unsigned full DW x DW product, truncated to the low DW bits. Two's-complement low bits are therefore also correct for signed use.
- Fairness: a requester that is continuously valid is granted within N_REQ grants.
- Simultaneous events: multiple valid bits in IDLE resolve by round-robin only, never by fixed priority.
- Reset mid-operation: an in-flight result is discarded and no rsp_valid pulse is emitted after reset. The first grant after reset goes to the lowest valid index.
- Invariants:
  - busy == (state != IDLE).
  - req_ready == 0 whenever busy=1.
  - rsp_valid implies state==RESP.

Decomposition:
- Shared package mul_share_pkg holds:
  - the state encoding (IDLE/CALC/RESP, one-hot 3-bit, matching the team's one-hot state style);
  - the default DW and MUL_LAT constants;
  - a function rr_pick(valid, ptr) returning the grant index.
- One sub-module, mul_multicycle (DW, MUL_LAT): holds the captured operands and produces the product. Its done output pulses after MUL_LAT cycles.
- The arbiter FSM and the round-robin logic stay in the top module.

Test Plan:
- Single request: requester 2 with a=7, b=6 in cycle 10 gives req_ready[2]=1 in cycle 10, then rsp_valid=1, rsp_id=2, rsp_data=42 in cycle 16 (MUL_LAT=5), with rsp_ready=1.
- All four valid continuously after reset: grants go in order 0,1,2,3,0. Each rsp_id matches, and grants are spaced by 7 cycles.
- Back-pressure: rsp_ready=0 for 4 cycles in RESP. rsp_data and rsp_id stay stable, req_ready stays 0 throughout, and the next grant comes only after rsp_ready=1.
- Wrap/truncation: a=0xFFFFFFFF, b=0xFFFFFFFF gives rsp_data=0x00000001. a=0x80000000, b=2 gives 0x00000000.
- Reset mid-CALC: sys_rst=1 at cycle 3 of CALC. No rsp_valid appears, busy=0 the next cycle, and requests 1 and 3 pending after reset grant 1 first.
- Operand change after accept: requester 0 changes req_a in the cycle after its grant. The result still uses the originally captured operands.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types, defaults and round-robin helper for the multiplier-sharing arbiter.
package mul_share_pkg;

  localparam int unsigned DEFAULT_DW      = 32;
  localparam int unsigned DEFAULT_MUL_LAT = 5;
  localparam int unsigned MAX_REQ         = 16;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    CALC = 3'b010,
    RESP = 3'b100
  } state_t;

  // First set bit of valid at or above ptr, wrapping at n. Returns 0 when none are set.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0]         ptr,
                                         input int unsigned        n);
    logic [3:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && valid[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_mul.sv
// Multi-cycle multiplier: captures operands on start, pulses done MUL_LAT cycles later.
module mul_multicycle
  import mul_share_pkg::*;
#(
  parameter int unsigned DW      = DEFAULT_DW,
  parameter int unsigned MUL_LAT = DEFAULT_MUL_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] product,
  output logic          done
);

  localparam int unsigned CW = $clog2(MUL_LAT + 1);

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [CW-1:0] cnt;
  logic          active;
  logic          last;

  assign last    = active && (cnt == CW'(MUL_LAT - 1));
  assign done    = last;
  assign product = DW'(op_a * op_b);

  // Operand capture and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      op_a   <= a;
      op_b   <= b;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      cnt <= cnt + CW'(1);
      if (last) active <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier among N_REQ requesters.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DW      = DEFAULT_DW,
  parameter int unsigned MUL_LAT = DEFAULT_MUL_LAT,
  parameter int unsigned IDW     = $clog2(N_REQ)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [DW-1:0]       rsp_data,
  input  logic                rsp_ready,
  output logic                busy
);

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] cur_id;
  logic           accept;
  logic [DW-1:0]  sel_a;
  logic [DW-1:0]  sel_b;
  logic [DW-1:0]  product;
  logic           done;

  assign grant     = IDW'(rr_pick(MAX_REQ'(req_valid), 4'(rr_ptr), N_REQ));
  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = accept ? (N_REQ'(1) << grant) : '0;
  assign sel_a     = req_a[grant*DW +: DW];
  assign sel_b     = req_b[grant*DW +: DW];
  assign busy      = (state != IDLE);

  mul_multicycle #(
    .DW      (DW),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .start   (accept),
    .a       (sel_a),
    .b       (sel_b),
    .product (product),
    .done    (done)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:    if (done)      state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Round-robin pointer, owner id and response registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rr_ptr    <= '0;
      cur_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant == IDW'(N_REQ - 1)) ? '0 : grant + IDW'(1);
        cur_id <= grant;
      end
      if (state == CALC && done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= cur_id;
        rsp_data  <= product;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter (N_REQ=4, DW=32, MUL_LAT=5).
module tb_mul_share_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 5;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_ready = 1'b1;
  logic            busy;

  int passed = 0;
  int total  = 0;

  mul_share_arbiter #(.N_REQ(N), .DW(DW), .MUL_LAT(LAT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int unsigned id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic set_ops(input int unsigned id, input logic [31:0] a, input logic [31:0] b);
    req_a[id*DW +: DW] = a;
    req_b[id*DW +: DW] = b;
  endtask

  // Waits for rsp_valid; n counts cycles from the caller's current cycle (already one past accept).
  task automatic wait_rsp(output int n, output logic ready_seen);
    n = 1;
    ready_seen = 1'b0;
    while (!rsp_valid && n < 30) begin
      if (req_ready != '0) ready_seen = 1'b1;
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    sys_rst = 1'b0;
  endtask

  task automatic run_vec(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int   n;
    logic rs;
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[id] = 1'b1;
    set_ops(id, a, b);
    req_valid = onehot;
    #1;
    check("vec_ready", req_ready, onehot);
    tick();
    req_valid = '0;
    set_ops(id, ~a, b + 32'd1);
    wait_rsp(n, rs);
    check("vec_latency", n, LAT + 1);
    check("vec_ready_quiet", rs, 0);
    check("vec_rsp_id", rsp_id, id);
    check("vec_rsp_data", rsp_data, exp);
    tick();
    check("vec_rsp_drop", rsp_valid, 0);
    check("vec_busy_drop", busy, 0);
  endtask

  initial begin
    int   n;
    logic rs;
    int   gidx[5];
    int   gcyc[5];
    int   ng;
    int   nr;
    int   order[5];
    logic bad;

    vecs[0] = '{2, 32'd7,          32'd6,          32'd42};
    vecs[1] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[2] = '{1, 32'h8000_0000,  32'd2,          32'h0000_0000};
    vecs[3] = '{3, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000};
    vecs[4] = '{0, 32'd12345,      32'd1000,       32'd12345000};
    vecs[5] = '{1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE};
    vecs[6] = '{3, 32'h0000_1234,  32'h0000_5678,  32'h0626_0060};
    order   = '{0, 1, 2, 3, 0};

    do_reset();
    for (int i = 0; i < 7; i++) run_vec(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp);

    // All four continuously valid straight out of reset.
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, i + 1, 32'd10);
    req_valid = 4'hF;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      #1;
      if (req_ready != '0) begin
        for (int k = 0; k < 4; k++) if (req_ready[k]) gidx[ng] = k;
        gcyc[ng] = c;
        ng++;
      end
      if (rsp_valid && nr < 5) begin
        check("rr_rsp_id", rsp_id, order[nr]);
        check("rr_rsp_data", rsp_data, (order[nr] + 1) * 10);
        nr++;
      end
      tick();
    end
    req_valid = '0;
    check("rr_grant_count", ng, 5);
    for (int k = 0; k < 5; k++) check("rr_grant_order", gidx[k], order[k]);
    for (int k = 1; k < 5; k++) check("rr_grant_spacing", gcyc[k] - gcyc[k-1], LAT + 2);
    n = 0;
    while (busy && n < 30) begin tick(); n++; end
    check("rr_drain", busy, 0);

    // Back-pressure in RESP.
    rsp_ready = 1'b0;
    set_ops(1, 32'd3, 32'd5);
    req_valid = 4'b0010;
    #1;
    check("bp_ready", req_ready, 4'b0010);
    tick();
    set_ops(2, 32'd9, 32'd9);
    req_valid = 4'b0100;
    wait_rsp(n, rs);
    check("bp_latency", n, LAT + 1);
    for (int k = 0; k < 4; k++) begin
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_id", rsp_id, 1);
      check("bp_hold_data", rsp_data, 15);
      check("bp_hold_ready", req_ready, 0);
      check("bp_hold_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", rsp_valid, 0);
    check("bp_next_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    wait_rsp(n, rs);
    check("bp2_rsp_id", rsp_id, 2);
    check("bp2_rsp_data", rsp_data, 81);
    tick();

    // Reset during the third CALC cycle.
    set_ops(0, 32'd2, 32'd3);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    check("mid_busy_before", busy, 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("mid_busy_after", busy, 0);
    check("mid_rsp_after", rsp_valid, 0);
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid || busy) bad = 1'b1;
      tick();
    end
    check("mid_no_stale_rsp", bad, 0);
    set_ops(1, 32'd4, 32'd5);
    set_ops(3, 32'd6, 32'd7);
    req_valid = 4'b1010;
    #1;
    check("mid_first_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    wait_rsp(n, rs);
    check("mid_rsp_id", rsp_id, 1);
    check("mid_rsp_data", rsp_data, 20);
    tick();
    check("mid_second_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    wait_rsp(n, rs);
    check("mid2_rsp_id", rsp_id, 3);
    check("mid2_rsp_data", rsp_data, 42);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
